brq_mem_arbiter: RTL and testbench
==================================

// Module: brq_mem_arbiter
// PURPOSE
//  Shares one core-side memory port (req/gnt/rvalid protocol) between the brq_core instruction and data interfaces.
//  Sits between brq_core and a single tlul_host_adapter, so one TL-UL host port serves both streams.
//  Arbitrates requests, holds the selection stable until grant, and routes in-order responses back to their requester.
// PARAMETERS
//  MAX_REQS  2   max outstanding downstream transactions; sets ID FIFO depth; must match adapter MAX_REQS
//  AW        32  address width
//  DW        32  data width
// PORTS
//  clock           in   1      single clock
//  reset           in   1      synchronous, active-high reset
//  instr_req_i     in   1      instr request (write-disabled: we=0, be=4'hF forced downstream)
//  instr_gnt_o     out  1      instr request accepted
//  instr_addr_i    in   AW     instr address
//  instr_rvalid_o  out  1      instr response valid
//  instr_rdata_o   out  DW     instr read data
//  instr_err_o     out  1      instr response error
//  data_req_i      in   1      data request
//  data_gnt_o      out  1      data request accepted
//  data_we_i       in   1      data write enable
//  data_be_i       in   DW/8   data byte enables
//  data_addr_i     in   AW     data address
//  data_wdata_i    in   DW     data write data
//  data_rvalid_o   out  1      data response valid
//  data_rdata_o    out  DW     data read data
//  data_err_o      out  1      data response error
//  req_o/gnt_i/we_o/be_o/addr_o/wdata_o   downstream request side, same widths and meanings as data_*
//  rvalid_i/rdata_i/err_i                 downstream response side
//  spurious_rsp_o  out  1      1-cycle pulse: rvalid_i seen with no outstanding transaction
// BEHAVIOUR
//  - Reset: all outputs 0; lock cleared; ID FIFO emptied; RR pointer set to data.
//  - FSM: ARB_IDLE -> ARB_LOCKED when a selected request is presented but not granted (req_o=1 and gnt_i=0).
//    ARB_LOCKED holds src_q and forwards that requester's fields unchanged until gnt_i -> ARB_IDLE.
//  - Requests are never re-arbitrated while locked. A dropped req in LOCKED is a protocol violation (assertion).
//  - Request path is combinational (0-cycle): req_o = selected req AND (count < MAX_REQS).
//  - Accept when req_o && gnt_i: pulse the selected *_gnt_o and push src ID {INSTR=0, DATA=1}.
//  - The unselected requester sees gnt=0.
//  - FIFO full (count == MAX_REQS): req_o=0 and no grants, even if a pop occurs the same cycle (registered full).
//  - Response: on rvalid_i, route rdata_i/err_i to the FIFO-head source's rvalid/rdata/err (combinational), then pop.
//    Non-target rvalid stays 0 and its rdata is 0.
//  - rvalid_i with an empty FIFO: no rvalid to either side; spurious_rsp_o=1 for that cycle.
//  - Push and pop in the same cycle: count unchanged, order preserved.
//  - Instr downstream fields: we_o=0, be_o='1, wdata_o=0.
//  - Reset mid-transaction: state discarded. Later responses to pre-reset requests count as spurious.
// CONFIGURATION
//  - BRQ_ARB_ROUND_ROBIN_EN defined: round-robin. The RR pointer flips to the other source after each accepted request.
//    On a tie, the source the pointer names wins.
//  - BRQ_ARB_ROUND_ROBIN_EN undefined: fixed priority, data over instr. The RR pointer is not built.
// STRUCTURE
//  - brq_pkg: typedef enum logic {ARB_SRC_INSTR, ARB_SRC_DATA} arb_src_e.
//  - brq_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e.
//  - Sub-module brq_arb_id_fifo: synchronous FIFO of arb_src_e, depth MAX_REQS.
//    Ports: push, pop, wdata, rdata, full, empty, count.
//  - Top: arbitration/lock FSM, request mux, response demux.
// TESTING
//  1. Both req idle; instr_req=1 addr 0x8000_0000, gnt_i=1 same cycle -> instr_gnt_o=1 same cycle.
//     Next-cycle rvalid_i with rdata 0xDEAD_BEEF -> instr_rvalid_o=1, instr_rdata_o=0xDEAD_BEEF.
//  2. Both req=1 in the same cycle, gnt_i=1, fixed priority -> data_gnt_o=1, instr_gnt_o=0.
//     With BRQ_ARB_ROUND_ROBIN_EN: data then instr on 2 consecutive cycles.
//  3. instr_req=1, gnt_i=0 for 3 cycles, data_req raised at cycle 1 -> addr_o stays the instr address.
//     gnt_i=1 at cycle 3 grants instr; data is granted on the next cycle.
//  4. Issue 2 accepted requests with no responses (MAX_REQS=2) -> req_o=0 while full.
//     One rvalid_i -> req_o reasserts next cycle.
//  5. Order: data then instr accepted; responses 0x1 then 0x2 -> data_rdata_o=0x1, then instr_rdata_o=0x2.
//     Responses are never misrouted.
//  6. rvalid_i=1 after reset with nothing issued -> spurious_rsp_o=1 for 1 cycle, no *_rvalid_o.
//     Assert reset with 1 outstanding -> count=0 and all outputs 0 the next cycle.

Source files
------------

// File: rtl/brq_pkg.sv
// Shared types for the brq memory arbiter: requester IDs and lock FSM states.
package brq_pkg;

    typedef enum logic {
        ARB_SRC_INSTR = 1'b0,
        ARB_SRC_DATA  = 1'b1
    } arb_src_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/brq_arb_id_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding downstream transaction.
module brq_arb_id_fifo
    import brq_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  arb_src_e      wdata,
    output arb_src_e      rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    arb_src_e        mem_q [DEPTH];
    arb_src_e        mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: ARB_SRC_INSTR};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/brq_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between brq_core instr and data sides.
// Define BRQ_ARB_ROUND_ROBIN_EN for round-robin; default is data-over-instr priority.
module brq_mem_arbiter
    import brq_pkg::*;
#(
    parameter int unsigned MAX_REQS = 2,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_req_i,
    output logic            instr_gnt_o,
    input  logic [AW-1:0]   instr_addr_i,
    output logic            instr_rvalid_o,
    output logic [DW-1:0]   instr_rdata_o,
    output logic            instr_err_o,
    input  logic            data_req_i,
    output logic            data_gnt_o,
    input  logic            data_we_i,
    input  logic [DW/8-1:0] data_be_i,
    input  logic [AW-1:0]   data_addr_i,
    input  logic [DW-1:0]   data_wdata_i,
    output logic            data_rvalid_o,
    output logic [DW-1:0]   data_rdata_o,
    output logic            data_err_o,
    output logic            req_o,
    input  logic            gnt_i,
    output logic            we_o,
    output logic [DW/8-1:0] be_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   wdata_o,
    input  logic            rvalid_i,
    input  logic [DW-1:0]   rdata_i,
    input  logic            err_i,
    output logic            spurious_rsp_o
);

    localparam int unsigned CW = $clog2(MAX_REQS + 1);

    arb_state_e    state_q, state_d;
    arb_src_e      src_q, src_d;
    arb_src_e      sel_src;
    arb_src_e      head_src;
    logic          sel_req;
    logic          accept;
    logic          rsp_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

`ifdef BRQ_ARB_ROUND_ROBIN_EN
    arb_src_e      rr_q, rr_d;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        sel_src = src_q;
        unique case (state_q)
            ARB_IDLE: begin
`ifdef BRQ_ARB_ROUND_ROBIN_EN
                if (instr_req_i && data_req_i) begin
                    sel_src = rr_q;
                end else if (instr_req_i) begin
                    sel_src = ARB_SRC_INSTR;
                end else begin
                    sel_src = ARB_SRC_DATA;
                end
`else
                sel_src = (instr_req_i && !data_req_i) ? ARB_SRC_INSTR : ARB_SRC_DATA;
`endif
            end
            ARB_LOCKED: sel_src = src_q;
            default:    sel_src = src_q;
        endcase

        sel_req = (sel_src == ARB_SRC_DATA) ? data_req_i : instr_req_i;
        // full is taken from the registered count, so a same-cycle pop never frees a slot
        req_o   = sel_req && !fifo_full && !reset;
        accept  = req_o && gnt_i;

        if (state_q == ARB_IDLE && req_o && !gnt_i) begin
            state_d = ARB_LOCKED;
            src_d   = sel_src;
        end else if (state_q == ARB_LOCKED && accept) begin
            state_d = ARB_IDLE;
        end
    end

`ifdef BRQ_ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (rr_q == ARB_SRC_DATA) ? ARB_SRC_INSTR : ARB_SRC_DATA;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            src_q   <= ARB_SRC_DATA;
`ifdef BRQ_ARB_ROUND_ROBIN_EN
            rr_q    <= ARB_SRC_DATA;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
`ifdef BRQ_ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        instr_gnt_o = accept && (sel_src == ARB_SRC_INSTR);
        data_gnt_o  = accept && (sel_src == ARB_SRC_DATA);
        we_o        = 1'b0;
        be_o        = '0;
        addr_o      = '0;
        wdata_o     = '0;
        if (!reset) begin
            if (sel_src == ARB_SRC_DATA) begin
                we_o    = data_we_i;
                be_o    = data_be_i;
                addr_o  = data_addr_i;
                wdata_o = data_wdata_i;
            end else begin
                be_o    = '1;
                addr_o  = instr_addr_i;
            end
        end
    end

    always_comb begin
        rsp_ok         = rvalid_i && !fifo_empty && !reset;
        spurious_rsp_o = rvalid_i && fifo_empty && !reset;
        instr_rvalid_o = rsp_ok && (head_src == ARB_SRC_INSTR);
        data_rvalid_o  = rsp_ok && (head_src == ARB_SRC_DATA);
        instr_rdata_o  = instr_rvalid_o ? rdata_i : '0;
        instr_err_o    = instr_rvalid_o && err_i;
        data_rdata_o   = data_rvalid_o ? rdata_i : '0;
        data_err_o     = data_rvalid_o && err_i;
    end

    brq_arb_id_fifo #(
        .DEPTH (MAX_REQS)
    ) u_id_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .pop   (rsp_ok),
        .wdata (sel_src),
        .rdata (head_src),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A locked requester must keep its request up until it is granted
    a_locked_req_held: assert property (@(posedge clock) disable iff (reset)
        (state_q == ARB_LOCKED) |->
        ((src_q == ARB_SRC_DATA) ? data_req_i : instr_req_i));

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        fifo_count <= CW'(MAX_REQS));

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Directed self-checking bench for brq_mem_arbiter (default fixed-priority build).
module tb_brq_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        req_o;
    logic        gnt_i;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        err_i;
    logic        spurious_rsp_o;

    int n_cmp = 0;
    int n_mis = 0;

    brq_mem_arbiter #(.MAX_REQS(2), .AW(32), .DW(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .req_o          (req_o),
        .gnt_i          (gnt_i),
        .we_o           (we_o),
        .be_o           (be_o),
        .addr_o         (addr_o),
        .wdata_o        (wdata_o),
        .rvalid_i       (rvalid_i),
        .rdata_i        (rdata_i),
        .err_i          (err_i),
        .spurious_rsp_o (spurious_rsp_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        gnt_i        = 1'b0;
        rvalid_i     = 1'b0;
        rdata_i      = '0;
        err_i        = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        // outputs held at 0 during reset even with stray inputs
        instr_req_i = 1'b1;
        gnt_i       = 1'b1;
        rvalid_i    = 1'b1;
        #2;
        chk("rst_req_o", 32'(req_o), 32'h0);
        chk("rst_ignt", 32'(instr_gnt_o), 32'h0);
        chk("rst_spur", 32'(spurious_rsp_o), 32'h0);
        chk("rst_irv", 32'(instr_rvalid_o), 32'h0);
        tick();
        idle_inputs();
        reset = 1'b0;
        #2;
        chk("idle_req_o", 32'(req_o), 32'h0);
        chk("idle_dgnt", 32'(data_gnt_o), 32'h0);
        tick();

        // 1: instr single request, 0-cycle grant, next-cycle response
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h8000_0000;
        gnt_i        = 1'b1;
        #2;
        chk("t1_req_o", 32'(req_o), 32'h1);
        chk("t1_ignt", 32'(instr_gnt_o), 32'h1);
        chk("t1_dgnt", 32'(data_gnt_o), 32'h0);
        chk("t1_addr", addr_o, 32'h8000_0000);
        chk("t1_we", 32'(we_o), 32'h0);
        chk("t1_be", 32'(be_o), 32'hF);
        chk("t1_wdata", wdata_o, 32'h0);
        tick();
        idle_inputs();
        rvalid_i = 1'b1;
        rdata_i  = 32'hDEAD_BEEF;
        #2;
        chk("t1_irv", 32'(instr_rvalid_o), 32'h1);
        chk("t1_irdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("t1_drv", 32'(data_rvalid_o), 32'h0);
        chk("t1_drdata", data_rdata_o, 32'h0);
        chk("t1_spur", 32'(spurious_rsp_o), 32'h0);
        tick();
        idle_inputs();

        // 2: simultaneous requests, data wins
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_2000;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_1000;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_wdata_i = 32'h0000_0055;
        gnt_i        = 1'b1;
        #2;
        chk("t2_dgnt", 32'(data_gnt_o), 32'h1);
        chk("t2_ignt", 32'(instr_gnt_o), 32'h0);
        chk("t2_addr", addr_o, 32'h0000_1000);
        chk("t2_we", 32'(we_o), 32'h1);
        chk("t2_be", 32'(be_o), 32'h3);
        chk("t2_wdata", wdata_o, 32'h0000_0055);
        tick();
        data_req_i = 1'b0;
        #2;
        chk("t2_ignt2", 32'(instr_gnt_o), 32'h1);
        chk("t2_addr2", addr_o, 32'h0000_2000);
        tick();

        // 4/5: FIFO full, registered full blocks even during a pop; data then instr order
        rvalid_i = 1'b1;
        rdata_i  = 32'h1;
        #2;
        chk("t4_full_req", 32'(req_o), 32'h0);
        chk("t4_full_ignt", 32'(instr_gnt_o), 32'h0);
        chk("t5_drv", 32'(data_rvalid_o), 32'h1);
        chk("t5_drdata", data_rdata_o, 32'h1);
        chk("t5_irv", 32'(instr_rvalid_o), 32'h0);
        tick();
        rdata_i = 32'h2;
        #2;
        chk("t4_reassert", 32'(req_o), 32'h1);
        chk("t4_ignt", 32'(instr_gnt_o), 32'h1);
        chk("t5_irv", 32'(instr_rvalid_o), 32'h1);
        chk("t5_irdata", instr_rdata_o, 32'h2);
        chk("t5_drv2", 32'(data_rvalid_o), 32'h0);
        tick();
        idle_inputs();
        rvalid_i = 1'b1;
        rdata_i  = 32'h3;
        err_i    = 1'b1;
        #2;
        chk("t5_pp_irv", 32'(instr_rvalid_o), 32'h1);
        chk("t5_pp_irdata", instr_rdata_o, 32'h3);
        chk("t5_pp_ierr", 32'(instr_err_o), 32'h1);
        chk("t5_pp_derr", 32'(data_err_o), 32'h0);
        tick();
        idle_inputs();

        // 3: lock on instr while data arrives later
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_3000;
        #2;
        chk("t3_c0_req", 32'(req_o), 32'h1);
        chk("t3_c0_addr", addr_o, 32'h0000_3000);
        tick();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_4000;
        data_be_i   = 4'hF;
        #2;
        chk("t3_c1_addr", addr_o, 32'h0000_3000);
        chk("t3_c1_dgnt", 32'(data_gnt_o), 32'h0);
        chk("t3_c1_be", 32'(be_o), 32'hF);
        tick();
        #2;
        chk("t3_c2_addr", addr_o, 32'h0000_3000);
        tick();
        gnt_i = 1'b1;
        #2;
        chk("t3_c3_ignt", 32'(instr_gnt_o), 32'h1);
        chk("t3_c3_dgnt", 32'(data_gnt_o), 32'h0);
        chk("t3_c3_addr", addr_o, 32'h0000_3000);
        tick();
        instr_req_i = 1'b0;
        #2;
        chk("t3_c4_dgnt", 32'(data_gnt_o), 32'h1);
        chk("t3_c4_addr", addr_o, 32'h0000_4000);
        tick();
        idle_inputs();
        rvalid_i = 1'b1;
        rdata_i  = 32'hA;
        #2;
        chk("t3_rsp_i", instr_rdata_o, 32'hA);
        chk("t3_rsp_dv", 32'(data_rvalid_o), 32'h0);
        tick();
        rdata_i = 32'hB;
        #2;
        chk("t3_rsp_d", data_rdata_o, 32'hB);
        chk("t3_rsp_iv", 32'(instr_rvalid_o), 32'h0);
        tick();

        // 6: spurious response on empty FIFO
        rdata_i = 32'hC;
        #2;
        chk("t6_spur", 32'(spurious_rsp_o), 32'h1);
        chk("t6_irv", 32'(instr_rvalid_o), 32'h0);
        chk("t6_drv", 32'(data_rvalid_o), 32'h0);
        tick();
        idle_inputs();
        #2;
        chk("t6_spur_end", 32'(spurious_rsp_o), 32'h0);

        // 6: reset with one outstanding; late response is spurious
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_5000;
        gnt_i        = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 32'h5;
        #2;
        chk("t6_post_spur", 32'(spurious_rsp_o), 32'h1);
        chk("t6_post_irv", 32'(instr_rvalid_o), 32'h0);
        chk("t6_post_req", 32'(req_o), 32'h0);
        chk("t6_post_addr", addr_o, 32'h0);
        tick();
        idle_inputs();
        // FIFO was emptied: exactly two more accepts fit
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_6000;
        gnt_i       = 1'b1;
        #2;
        chk("t6_cnt_a1", 32'(data_gnt_o), 32'h1);
        tick();
        #2;
        chk("t6_cnt_a2", 32'(data_gnt_o), 32'h1);
        tick();
        #2;
        chk("t6_cnt_full", 32'(req_o), 32'h0);
        tick();
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
